fp8_nibble_loader: RTL and testbench
====================================

FP8_NIBBLE_LOADER -- requirements
Module: fp8_nibble_loader

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles data/ctrl are driven before strobe rises, legal range 1..15.
REQ-002 Parameter PULSE_CYC, default 1: cycles strobe is held high, legal range 1..15.
REQ-003 Parameter SETTLE_CYC, default 2: cycles waited after the last nibble before bus_result is sampled, legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 ena  input  1  design enable; gates operand acceptance only.
REQ-007 op_valid  input  1  operand pair offered.
REQ-008 op_ready  output  1  operand pair can be accepted.
REQ-009 op_a, op_b  input  8 each  FP8 operands (sign, 4-bit exponent, 3-bit mantissa).
REQ-010 bus_data  output  4  nibble to the multiplier's data pins.
REQ-011 bus_ctrl  output  3  store-select code to the multiplier's ctrl pins.
REQ-012 bus_strobe  output  1  store strobe to the multiplier's strobe pin.
REQ-013 bus_result  input  8  unregistered FP8 product returned by the multiplier.
REQ-014 res_valid  output  1  product available.
REQ-015 res_data  output  8  captured product.
REQ-016 res_ready  input  1  consumer accepts the product.
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 States SHALL be IDLE, SETUP, PULSE, HOLD, SETTLE and RESP, with a 2-bit nibble index and a 4-bit phase counter.
REQ-019 op_ready SHALL equal (state==IDLE) & ena & rst_n; acceptance is op_valid & op_ready at a rising edge, and op_a/op_b are then latched internally, later changes being ignored.
REQ-020 The nibble order SHALL be: 0 = op_a[3:0] with ctrl 3'b000; 1 = op_a[7:4] with 3'b100; 2 = op_b[3:0] with 3'b010; 3 = op_b[7:4] with 3'b110.
REQ-021 For each nibble the block SHALL spend SETUP_CYC cycles in SETUP (strobe 0), PULSE_CYC cycles in PULSE (strobe 1), then 1 cycle in HOLD (strobe 0), with bus_data/bus_ctrl constant across all three phases.
REQ-022 After HOLD of nibble 0..2 the block SHALL go to SETUP of the next nibble; after HOLD of nibble 3 it SHALL go to SETTLE.
REQ-023 On the last SETTLE_CYC cycle the block SHALL load bus_result into res_data and enter RESP; res_valid is high exactly while the state is RESP.
REQ-024 Latency: if acceptance occurs at edge 0, res_valid SHALL first be high in cycle 4*(SETUP_CYC+PULSE_CYC+1)+SETTLE_CYC+1, which is 15 with the defaults.
REQ-025 In RESP, res_data SHALL be stable until res_valid & res_ready at an edge; the block then returns to IDLE, and op_ready rises the following cycle.
REQ-026 If res_ready is already high when RESP is entered, the handshake SHALL complete on the first RESP edge.
REQ-027 res_data SHALL retain its last value after the handshake until the next capture.
REQ-028 Outside SETUP/PULSE/HOLD, bus_ctrl SHALL be 3'b001 (reserved, non-store code), bus_data 4'h0 and bus_strobe 0, so that no stray store occurs.
REQ-029 bus_strobe SHALL be driven directly from a flop, with no combinational path to it.
REQ-030 ena falling mid-transfer SHALL NOT stall or abort the transfer.

Reset
REQ-031 While rst_n is low, asynchronously: state IDLE, nibble index 0, counters 0, latched operands 0, res_data 8'h00, res_valid 0, busy 0, op_ready 0, bus_strobe 0, bus_ctrl 3'b001, bus_data 4'h0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no res_valid pulse; bus_strobe SHALL fall without waiting for a clock edge.
REQ-033 After rst_n rises, the first acceptance SHALL be possible at the first rising edge where op_valid & ena are high.

Verification
REQ-034 Hold rst_n low with op_valid=ena=1 -> op_ready=0, bus_ctrl=001, strobe=0, res_data=00; release -> op_ready=1.
REQ-035 Defaults, op_a=0x38, op_b=0x40, bus_result model 0x40 -> (data,ctrl) pairs (8,000),(3,100),(0,010),(4,110); strobe high in cycles 2,5,8,11; res_valid in cycle 15 with res_data=0x40.
REQ-036 res_ready held low for 10 cycles after res_valid -> res_valid=1, res_data constant, op_ready=0, busy=1; raise res_ready -> op_ready=1 the cycle after the handshake.
REQ-037 rst_n pulsed low during PULSE of nibble 2 -> strobe=0 before the next edge, ctrl=001, no res_valid; new operands then complete normally.
REQ-038 ena=0 with op_valid=1 for 5 cycles -> no acceptance, busy=0; ena=1 -> accepted on the next edge.
REQ-039 SETUP_CYC=2, PULSE_CYC=3, SETTLE_CYC=1 -> each strobe is high for 3 cycles, and res_valid first rises in cycle 26.

Source files
------------

// File: rtl/fp8_nibble_loader_if.sv
// ---------------------------------------------------------------------------
// fp8_nibble_loader_if
// Groups the operand handshake, the nibble bus to the external multiplier and
// the result handshake of fp8_nibble_loader.
//   op_valid/op_ready/op_a/op_b   : operand pair handshake (into the loader)
//   bus_data/bus_ctrl/bus_strobe  : nibble store bus (out of the loader)
//   bus_result                    : combinational FP8 product from multiplier
//   res_valid/res_data/res_ready  : product handshake (out of the loader)
// Modport slave is the loader; modport master is its environment.
// ---------------------------------------------------------------------------
interface fp8_nibble_loader_if;
   logic       op_valid;
   logic       op_ready;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [3:0] bus_data;
   logic [2:0] bus_ctrl;
   logic       bus_strobe;
   logic [7:0] bus_result;
   logic       res_valid;
   logic [7:0] res_data;
   logic       res_ready;

   modport slave (
      input  op_valid, op_a, op_b, bus_result, res_ready,
      output op_ready, bus_data, bus_ctrl, bus_strobe, res_valid, res_data
   );

   modport master (
      output op_valid, op_a, op_b, bus_result, res_ready,
      input  op_ready, bus_data, bus_ctrl, bus_strobe, res_valid, res_data
   );
endinterface

// File: rtl/fp8_nibble_loader.sv
// ---------------------------------------------------------------------------
// fp8_nibble_loader
// Accepts an FP8 operand pair, loads it nibble by nibble into an external
// multiplier through a data/ctrl/strobe bus, waits for the product to settle,
// captures it and offers it on a valid/ready handshake.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   ena   : enable, gates operand acceptance only
//   busy  : high whenever the controller is not idle
//   io    : fp8_nibble_loader_if.slave (operand, bus and result signals)
// Parameters (legal range 1..15 each):
//   SETUP_CYC  : cycles data/ctrl are stable before strobe rises
//   PULSE_CYC  : cycles strobe is held high
//   SETTLE_CYC : cycles waited after the last nibble before sampling result
// ---------------------------------------------------------------------------
module fp8_nibble_loader #(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned PULSE_CYC  = 1,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   output logic                     busy,
   fp8_nibble_loader_if.slave       io
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      PULSE  = 3'd2,
      HOLD   = 3'd3,
      SETTLE = 3'd4,
      RESP   = 3'd5
   } state_t;

   localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LAST  = 4'(PULSE_CYC - 1);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [2:0] CTRL_IDLE   = 3'b001;

   state_t     state_reg,    state_next;
   logic [1:0] nib_reg,      nib_next;
   logic [3:0] phase_reg,    phase_next;
   logic [7:0] op_a_reg;
   logic [7:0] op_b_reg;
   logic [7:0] res_data_reg;
   logic [3:0] bus_data_reg, bus_data_next;
   logic [2:0] bus_ctrl_reg, bus_ctrl_next;
   logic       strobe_reg,   strobe_next;

   logic       op_ready;
   logic       accept;
   logic       capture;
   logic [7:0] src_a;
   logic [7:0] src_b;

   assign op_ready = (state_reg == IDLE) & ena & rst_n;
   assign accept   = io.op_valid & op_ready;

   // On the accepting edge the operand registers are not loaded yet, so the
   // first nibble must come straight from the inputs.
   assign src_a = accept ? io.op_a : op_a_reg;
   assign src_b = accept ? io.op_b : op_b_reg;

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      nib_next   = nib_reg;
      phase_next = phase_reg;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = SETUP;
               nib_next   = 2'd0;
               phase_next = 4'd0;
            end
         end
         SETUP: begin
            if (phase_reg == SETUP_LAST) begin
               state_next = PULSE;
               phase_next = 4'd0;
            end else begin
               phase_next = phase_reg + 4'd1;
            end
         end
         PULSE: begin
            if (phase_reg == PULSE_LAST) begin
               state_next = HOLD;
               phase_next = 4'd0;
            end else begin
               phase_next = phase_reg + 4'd1;
            end
         end
         HOLD: begin
            phase_next = 4'd0;
            if (nib_reg == 2'd3) begin
               state_next = SETTLE;
            end else begin
               state_next = SETUP;
               nib_next   = nib_reg + 2'd1;
            end
         end
         SETTLE: begin
            if (phase_reg == SETTLE_LAST) begin
               capture    = 1'b1;
               state_next = RESP;
               phase_next = 4'd0;
            end else begin
               phase_next = phase_reg + 4'd1;
            end
         end
         RESP: begin
            if (io.res_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Bus values for the coming cycle; registered so strobe has no
   // combinational path to the pin. Non-transfer states park the bus on the
   // reserved non-store ctrl code.
   always_comb begin
      bus_data_next = 4'h0;
      bus_ctrl_next = CTRL_IDLE;
      strobe_next   = 1'b0;
      if ((state_next == SETUP) || (state_next == PULSE) || (state_next == HOLD)) begin
         case (nib_next)
            2'd0: begin bus_data_next = src_a[3:0]; bus_ctrl_next = 3'b000; end
            2'd1: begin bus_data_next = src_a[7:4]; bus_ctrl_next = 3'b100; end
            2'd2: begin bus_data_next = src_b[3:0]; bus_ctrl_next = 3'b010; end
            default: begin bus_data_next = src_b[7:4]; bus_ctrl_next = 3'b110; end
         endcase
         strobe_next = (state_next == PULSE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         nib_reg      <= 2'd0;
         phase_reg    <= 4'd0;
         op_a_reg     <= 8'h00;
         op_b_reg     <= 8'h00;
         res_data_reg <= 8'h00;
         bus_data_reg <= 4'h0;
         bus_ctrl_reg <= CTRL_IDLE;
         strobe_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         nib_reg      <= nib_next;
         phase_reg    <= phase_next;
         bus_data_reg <= bus_data_next;
         bus_ctrl_reg <= bus_ctrl_next;
         strobe_reg   <= strobe_next;
         if (accept) begin
            op_a_reg <= io.op_a;
            op_b_reg <= io.op_b;
         end
         if (capture) begin
            res_data_reg <= io.bus_result;
         end
      end
   end

   assign busy          = (state_reg != IDLE);
   assign io.op_ready   = op_ready;
   assign io.bus_data   = bus_data_reg;
   assign io.bus_ctrl   = bus_ctrl_reg;
   assign io.bus_strobe = strobe_reg;
   assign io.res_valid  = (state_reg == RESP);
   assign io.res_data   = res_data_reg;

endmodule

// File: tb/tb_fp8_nibble_loader.sv
// ---------------------------------------------------------------------------
// tb_fp8_nibble_loader
// Two loader instances (default timing and SETUP=2/PULSE=3/SETTLE=1) share
// one stimulus driver selected by sel. Each instance talks to a behavioural
// multiplier that stores nibbles on strobe and returns an FP8 product.
// Expected bus waveforms come from cycle arithmetic on the timing
// parameters; expected products come from the original operands.
// ---------------------------------------------------------------------------
module tb_fp8_nibble_loader;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       op_valid;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       res_ready;
   logic       sel;
   logic       busy0;
   logic       busy2;

   int checks;
   int errors;

   fp8_nibble_loader_if if0 ();
   fp8_nibble_loader_if if2 ();

   fp8_nibble_loader u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .busy  (busy0),
      .io    (if0.slave)
   );

   fp8_nibble_loader #(
      .SETUP_CYC  (2),
      .PULSE_CYC  (3),
      .SETTLE_CYC (1)
   ) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .busy  (busy2),
      .io    (if2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Simple FP8 (1/4/3, bias 7) multiply; exponent 0 treated as zero,
   // mantissa truncated, overflow saturates.
   function automatic logic [7:0] fp8_mul(input logic [7:0] a, input logic [7:0] b);
      logic s;
      int   e;
      int   m;
      s = a[7] ^ b[7];
      if (a[6:3] == 4'd0 || b[6:3] == 4'd0) return {s, 7'd0};
      m = (8 + int'(a[2:0])) * (8 + int'(b[2:0]));
      e = int'(a[6:3]) + int'(b[6:3]) - 7;
      if (m >= 128) begin
         m = m / 2;
         e = e + 1;
      end
      if (e <= 0) return {s, 7'd0};
      if (e > 15) return {s, 7'h7f};
      return {s, 4'(e), 3'((m / 8) % 8)};
   endfunction

   // Behavioural multipliers: one store register per ctrl code.
   logic [3:0] m0_alo, m0_ahi, m0_blo, m0_bhi;
   logic [3:0] m2_alo, m2_ahi, m2_blo, m2_bhi;

   always @(posedge clk) begin
      if (if0.bus_strobe) begin
         case (if0.bus_ctrl)
            3'b000: m0_alo <= if0.bus_data;
            3'b100: m0_ahi <= if0.bus_data;
            3'b010: m0_blo <= if0.bus_data;
            3'b110: m0_bhi <= if0.bus_data;
            default: ;
         endcase
      end
      if (if2.bus_strobe) begin
         case (if2.bus_ctrl)
            3'b000: m2_alo <= if2.bus_data;
            3'b100: m2_ahi <= if2.bus_data;
            3'b010: m2_blo <= if2.bus_data;
            3'b110: m2_bhi <= if2.bus_data;
            default: ;
         endcase
      end
   end

   assign if0.bus_result = fp8_mul({m0_ahi, m0_alo}, {m0_bhi, m0_blo});
   assign if2.bus_result = fp8_mul({m2_ahi, m2_alo}, {m2_bhi, m2_blo});

   assign if0.op_valid  = op_valid & ~sel;
   assign if0.op_a      = op_a;
   assign if0.op_b      = op_b;
   assign if0.res_ready = res_ready & ~sel;
   assign if2.op_valid  = op_valid & sel;
   assign if2.op_a      = op_a;
   assign if2.op_b      = op_b;
   assign if2.res_ready = res_ready & sel;

   logic       obs_op_ready;
   logic [3:0] obs_bus_data;
   logic [2:0] obs_bus_ctrl;
   logic       obs_strobe;
   logic       obs_res_valid;
   logic [7:0] obs_res_data;
   logic       obs_busy;

   assign obs_op_ready  = sel ? if2.op_ready   : if0.op_ready;
   assign obs_bus_data  = sel ? if2.bus_data   : if0.bus_data;
   assign obs_bus_ctrl  = sel ? if2.bus_ctrl   : if0.bus_ctrl;
   assign obs_strobe    = sel ? if2.bus_strobe : if0.bus_strobe;
   assign obs_res_valid = sel ? if2.res_valid  : if0.res_valid;
   assign obs_res_data  = sel ? if2.res_data   : if0.res_data;
   assign obs_busy      = sel ? busy2          : busy0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected bus in cycle c after acceptance (c=1 is the first cycle).
   function automatic void exp_bus(input int c, input int s_cyc, input int p_cyc,
                                   input logic [7:0] a, input logic [7:0] b,
                                   output logic [3:0] d, output logic [2:0] ct,
                                   output logic st);
      int per;
      int n;
      int w;
      per = s_cyc + p_cyc + 1;
      n   = (c - 1) / per;
      w   = (c - 1) % per;
      d   = 4'h0;
      ct  = 3'b001;
      st  = 1'b0;
      if (n < 4) begin
         case (n)
            0:       begin d = a[3:0]; ct = 3'b000; end
            1:       begin d = a[7:4]; ct = 3'b100; end
            2:       begin d = b[3:0]; ct = 3'b010; end
            default: begin d = b[7:4]; ct = 3'b110; end
         endcase
         st = (w >= s_cyc) && (w < s_cyc + p_cyc);
      end
   endfunction

   // One full transaction on the selected instance, checked every cycle.
   task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                          input int s_cyc, input int p_cyc, input int t_cyc,
                          input int rr_wait, input bit toggle_ena);
      int         lat;
      logic [3:0] ed;
      logic [2:0] ec;
      logic       es;
      logic [7:0] er;
      lat = 4 * (s_cyc + p_cyc + 1) + t_cyc + 1;
      er  = fp8_mul(a, b);
      ena       = 1'b1;
      op_valid  = 1'b1;
      op_a      = a;
      op_b      = b;
      res_ready = (rr_wait == 0);
      #1;
      check_val("op_ready_idle", obs_op_ready, 1);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op_a     = 8'($urandom);
      op_b     = 8'($urandom);
      for (int c = 1; c <= lat + rr_wait; c++) begin
         @(negedge clk);
         exp_bus(c, s_cyc, p_cyc, a, b, ed, ec, es);
         check_val("bus_data", obs_bus_data, ed);
         check_val("bus_ctrl", obs_bus_ctrl, ec);
         check_val("bus_strobe", obs_strobe, es);
         check_val("res_valid", obs_res_valid, (c >= lat));
         check_val("busy", obs_busy, 1);
         if (c >= lat) check_val("res_data", obs_res_data, er);
         if (toggle_ena) ena = 1'($urandom_range(0, 1));
         #1;
         check_val("op_ready_busy", obs_op_ready, 0);
         if (c == lat + rr_wait) res_ready = 1'b1;
      end
      @(negedge clk);
      res_ready = 1'b0;
      ena       = 1'b1;
      #1;
      check_val("res_valid_after", obs_res_valid, 0);
      check_val("busy_after", obs_busy, 0);
      check_val("op_ready_after", obs_op_ready, 1);
      check_val("res_data_kept", obs_res_data, er);
      check_val("bus_ctrl_idle", obs_bus_ctrl, 3'b001);
      check_val("strobe_idle", obs_strobe, 0);
      $display("txn sel=%0d a=%02h b=%02h rr_wait=%0d res=%02h exp=%02h",
               sel, a, b, rr_wait, obs_res_data, er);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      sel       = 1'b0;
      rst_n     = 1'b0;
      ena       = 1'b1;
      op_valid  = 1'b1;
      op_a      = 8'h00;
      op_b      = 8'h00;
      res_ready = 1'b0;

      // Reset held with a pending request
      repeat (3) @(negedge clk);
      check_val("rst_op_ready", obs_op_ready, 0);
      check_val("rst_bus_ctrl", obs_bus_ctrl, 3'b001);
      check_val("rst_bus_data", obs_bus_data, 0);
      check_val("rst_strobe", obs_strobe, 0);
      check_val("rst_res_data", obs_res_data, 8'h00);
      check_val("rst_res_valid", obs_res_valid, 0);
      check_val("rst_busy", obs_busy, 0);
      rst_n = 1'b1;
      #1;
      check_val("rel_op_ready", obs_op_ready, 1);
      $display("reset released, op_ready=%0d", obs_op_ready);

      // Directed default-timing transaction, result ready immediately
      run_txn(8'h38, 8'h40, 1, 1, 2, 0, 1'b0);
      check_val("directed_res", obs_res_data, 8'h40);

      // Consumer stalls for 10 cycles
      run_txn(8'h38, 8'h40, 1, 1, 2, 10, 1'b0);

      // Reset during PULSE of nibble 2
      ena      = 1'b1;
      op_valid = 1'b1;
      op_a     = 8'h5a;
      op_b     = 8'h3c;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      repeat (8) @(negedge clk);
      check_val("pulse2_strobe", obs_strobe, 1);
      check_val("pulse2_ctrl", obs_bus_ctrl, 3'b010);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_strobe", obs_strobe, 0);
      check_val("arst_ctrl", obs_bus_ctrl, 3'b001);
      check_val("arst_busy", obs_busy, 0);
      check_val("arst_op_ready", obs_op_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         check_val("arst_no_valid", obs_res_valid, 0);
         check_val("arst_idle", obs_busy, 0);
      end
      $display("mid-transfer reset aborted cleanly");
      run_txn(8'h47, 8'hc1, 1, 1, 2, 1, 1'b0);

      // ena low blocks acceptance
      ena      = 1'b0;
      op_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_val("ena0_op_ready", obs_op_ready, 0);
         check_val("ena0_busy", obs_busy, 0);
      end
      $display("ena low held off acceptance for 5 cycles");
      run_txn(8'h29, 8'h3b, 1, 1, 2, 0, 1'b0);

      // Randomized transactions with ena toggling mid-transfer
      for (int i = 0; i < 8; i++) begin
         run_txn(8'($urandom), 8'($urandom), 1, 1, 2, $urandom_range(0, 4), 1'b1);
      end

      // Second instance: SETUP=2, PULSE=3, SETTLE=1 (latency 26)
      sel = 1'b1;
      #1;
      run_txn(8'h38, 8'h40, 2, 3, 1, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         run_txn(8'($urandom), 8'($urandom), 2, 3, 1, $urandom_range(0, 3), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
